aux_cnt_ctrl: RTL and testbench
===============================

Name: aux_cnt_ctrl

Overview:
Control FSM that sits directly upstream of the 6-bit auxiliary counter register and drives its aux_reg_i, aux_reg_en and aux_reg_clr inputs.
- Reads the register's current value back through aux_cnt_i.
- Sequences an index loop 0..limit-1 and presents each index to a downstream datapath over a valid/ack handshake.
- Reports busy and done to the top-level controller.

Parameters:
CNT_W, 6, width of the index and limit; must equal the auxiliary register width.
TO_CYCLES, 255, ack-wait timeout in clock cycles (used only when AUX_CNT_CTRL_TIMEOUT_EN is defined).

Ports:
clk  input  1  clock, rising edge.
rstn  input  1  reset, asynchronous, active-low.
start_i  input  1  single-cycle request to begin a loop; ignored unless IDLE.
abort_i  input  1  terminate the current loop.
limit_i  input  CNT_W  iteration count; sampled when start_i is accepted.
aux_cnt_i  input  CNT_W  feedback from the auxiliary register output.
idx_ack_i  input  1  downstream accepts the current index.
aux_reg_i  output  CNT_W  next counter value, equal to aux_cnt_i+1.
aux_reg_en  output  1  load strobe to the register.
aux_reg_clr  output  1  clear strobe to the register.
idx_valid_o  output  1  index available.
idx_o  output  CNT_W  current index, equal to aux_cnt_i.
busy_o  output  1  high in any state other than IDLE.
done_o  output  1  one-cycle pulse on normal completion.
timeout_o  output  1  one-cycle pulse on ack timeout.

Behaviour:
- Reset:
  - state=IDLE, limit_q=0, all outputs 0.
  - aux_reg_i follows aux_cnt_i+1 combinationally.
- Outputs:
  - All control outputs are Moore-decoded from the state register; there is no input-to-output combinational path.
  - Exceptions: aux_reg_i and idx_o are combinational on aux_cnt_i.
- States and transitions:
  - IDLE: on start_i, latch limit_q<=limit_i, go to CLR.
  - CLR: aux_reg_clr=1 for exactly one cycle. If limit_q==0, go to DONE; else go to ISSUE.
  - ISSUE: idx_valid_o=1 and idx_o=aux_cnt_i, held stable until idx_ack_i.
    - On ack with aux_cnt_i==limit_q-1, go to DONE.
    - On any other ack, go to INCR.
  - INCR: aux_reg_en=1 (register loads aux_cnt_i+1), then go to ISSUE. This gives a one-cycle valid bubble between indices.
  - DONE: done_o=1 for one cycle, then go to IDLE. The register retains the last index; no clear is issued.
  - ABORT: aux_reg_clr=1 for one cycle, then go to IDLE. done_o is not asserted.
- Latency:
  - start_i accepted at cycle 0, CLR at cycle 1, first idx_valid_o (idx 0) at cycle 2.
  - Ack at cycle n gives the next valid at cycle n+2.
- abort_i:
  - Active in CLR, ISSUE, INCR or DONE: next state is ABORT.
  - Has priority over idx_ack_i and over completion.
  - Ignored in IDLE and ABORT.
- start_i while busy_o=1 is ignored; limit_q is unchanged.
- Width rules:
  - aux_reg_i wraps modulo 2^CNT_W.
  - The maximum limit is 2^CNT_W-1, so the last index is 2^CNT_W-2 and the wrap is never loaded in normal operation.
- Reset asserted mid-loop returns immediately to the reset values; a new start_i is required.

Optional Feature:
AUX_CNT_CTRL_TIMEOUT_EN
- Defined:
  - An internal counter clears on entry to ISSUE and increments each cycle in ISSUE without ack.
  - When it reaches TO_CYCLES, next state is ABORT and timeout_o pulses for one cycle, coincident with the ABORT state.
  - An ack in the same cycle as the timeout wins; the timeout is not taken.
  - abort_i in the same cycle takes ABORT without a timeout_o pulse.
- Undefined:
  - No counter logic; ISSUE waits indefinitely for ack.
  - timeout_o port remains present, tied to 0.

Decomposition:
- Shared package/header (aux_pkg): state encodings (IDLE, CLR, ISSUE, INCR, DONE, ABORT as 3-bit localparams), default CNT_W=6, default TO_CYCLES.
- One natural sub-module: aux_timeout_cnt (clear, enable, expired flag), instantiated only under AUX_CNT_CTRL_TIMEOUT_EN.

Test Plan:
1. limit_i=3, ack one cycle after each valid. Required: clr at cycle 1; idx_o 0,1,2 with one-cycle bubbles; done_o one cycle after the third ack; register ends at 2.
2. limit_i=0, start. Required: clr pulse, then done_o the next cycle; idx_valid_o never asserted.
3. limit_i=5, ack withheld 10 cycles on idx 1. Required: idx_valid_o and idx_o=1 stable for all 10 cycles; loop completes with 5 indices.
4. abort_i asserted on the same cycle as ack of idx 2. Required: ABORT with one-cycle aux_reg_clr, no aux_reg_en, no done_o, busy_o low the following cycle.
5. start_i pulsed during a running loop with a different limit_i. Required: ignored, original count preserved; rstn low mid-loop forces all outputs to 0 immediately.
6. Timeout (macro defined, TO_CYCLES=4), no ack. Required: timeout_o pulse plus aux_reg_clr after 4 wait cycles. Repeat with ack on the expiry cycle: no timeout; loop continues.

Source files
------------

// File: rtl/aux_pkg.sv
// Shared definitions for the auxiliary counter control block:
// FSM state encodings and default parameter values.
package aux_pkg;

  localparam int CNT_W_DEF     = 6;
  localparam int TO_CYCLES_DEF = 255;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ISSUE = 3'd2,
    INCR  = 3'd3,
    DONE  = 3'd4,
    ABORT = 3'd5
  } state_t;

endpackage

// File: rtl/aux_timeout_cnt.sv
// Ack-wait timeout counter. Held at zero while clr is high, counts the
// cycles in which en is high, and flags expired on the cycle that would
// be the TO_CYCLES-th counted cycle.
module aux_timeout_cnt
  import aux_pkg::*;
#(
  parameter int TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TO_CYCLES + 1);

  logic [W-1:0] cnt_q;

  // expired is raised on the last permitted wait cycle so the FSM can
  // move to ABORT exactly TO_CYCLES cycles after ISSUE was entered.
  assign expired = (cnt_q == W'(TO_CYCLES - 1));

  // Wait-cycle counter; saturates once expired so it never wraps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/aux_cnt_ctrl.sv
// Control FSM for the 6-bit auxiliary counter register. Clears the
// register, walks indices 0..limit-1 out over a valid/ack handshake
// (incrementing the register between indices) and reports busy/done.
// Optional build macro: AUX_CNT_CTRL_TIMEOUT_EN adds an ack-wait timeout.
//
// Handshake: idx_valid_o is high for the whole ISSUE state and idx_o is
// held stable until the cycle in which idx_ack_i is sampled high with
// idx_valid_o; that cycle completes the transfer of the current index.
// idx_ack_i is ignored whenever idx_valid_o is low.
module aux_cnt_ctrl
  import aux_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] limit_i,
  input  logic [CNT_W-1:0] aux_cnt_i,
  input  logic             idx_ack_i,
  output logic [CNT_W-1:0] aux_reg_i,
  output logic             aux_reg_en,
  output logic             aux_reg_clr,
  output logic             idx_valid_o,
  output logic [CNT_W-1:0] idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] limit_q;
  logic             timeout_q, timeout_d;
  logic             to_hit;
  logic             last_idx;

`ifdef AUX_CNT_CTRL_TIMEOUT_EN
  aux_timeout_cnt #(
    .TO_CYCLES (TO_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (state_q != ISSUE),
    .en      ((state_q == ISSUE) && !idx_ack_i),
    .expired (to_hit)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^TO_CYCLES;
  assign to_hit     = 1'b0;
`endif

  // The register is the index; the last index is limit-1 (limit is never
  // zero in ISSUE because CLR bypasses straight to DONE).
  assign last_idx = (aux_cnt_i == limit_q - CNT_W'(1));

  // Next-state logic; abort outranks ack, completion and timeout.
  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE:  if (start_i) state_d = CLR;
      CLR: begin
        if (abort_i)              state_d = ABORT;
        else if (limit_q == '0)   state_d = DONE;
        else                      state_d = ISSUE;
      end
      ISSUE: begin
        if (abort_i) begin
          state_d = ABORT;
        end else if (idx_ack_i) begin
          state_d = last_idx ? DONE : INCR;
        end else if (to_hit) begin
          state_d   = ABORT;
          timeout_d = 1'b1;
        end
      end
      INCR:  state_d = abort_i ? ABORT : ISSUE;
      DONE:  state_d = abort_i ? ABORT : IDLE;
      ABORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, timeout pulse flag and limit capture on accepted start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      timeout_q <= 1'b0;
      limit_q   <= '0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
      if ((state_q == IDLE) && start_i) limit_q <= limit_i;
    end
  end

  // Control outputs are decoded from registered state only.
  assign aux_reg_clr = (state_q == CLR) || (state_q == ABORT);
  assign aux_reg_en  = (state_q == INCR);
  assign idx_valid_o = (state_q == ISSUE);
  assign done_o      = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign timeout_o   = timeout_q;

  // Datapath taps on the register value; wraps modulo 2^CNT_W.
  assign aux_reg_i = aux_cnt_i + CNT_W'(1);
  assign idx_o     = aux_cnt_i;

endmodule

// File: tb/tb_aux_cnt_ctrl.sv
// Bench for aux_cnt_ctrl. Models the auxiliary register around the DUT,
// drives randomized loops and checks each cycle against the expected
// index stream and protocol timing.
module tb_aux_cnt_ctrl;

  localparam int W  = 6;
  localparam int TO = 4;
`ifdef AUX_CNT_CTRL_TIMEOUT_EN
  localparam int MAX_WAIT = TO - 1;
  localparam int HOLD_LEN = TO - 1;
`else
  localparam int MAX_WAIT = 5;
  localparam int HOLD_LEN = 10;
`endif

  logic         clk;
  logic         rstn;
  logic         start_i;
  logic         abort_i;
  logic [W-1:0] limit_i;
  logic [W-1:0] aux_cnt;
  logic         idx_ack_i;
  logic [W-1:0] aux_reg_i;
  logic         aux_reg_en;
  logic         aux_reg_clr;
  logic         idx_valid_o;
  logic [W-1:0] idx_o;
  logic         busy_o;
  logic         done_o;
  logic         timeout_o;

  int           n_vec;
  int           n_bad;
  logic [W-1:0] exp_q[$];

  aux_cnt_ctrl #(
    .CNT_W     (W),
    .TO_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .limit_i     (limit_i),
    .aux_cnt_i   (aux_cnt),
    .idx_ack_i   (idx_ack_i),
    .aux_reg_i   (aux_reg_i),
    .aux_reg_en  (aux_reg_en),
    .aux_reg_clr (aux_reg_clr),
    .idx_valid_o (idx_valid_o),
    .idx_o       (idx_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .timeout_o   (timeout_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The auxiliary counter register the controller drives.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            aux_cnt <= '0;
    else if (aux_reg_clr) aux_cnt <= '0;
    else if (aux_reg_en)  aux_cnt <= aux_reg_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic v, input logic en, input logic clr,
                           input logic done, input logic busy, input logic to);
    check_eq({tag, ".valid"},   32'(idx_valid_o), 32'(v));
    check_eq({tag, ".en"},      32'(aux_reg_en),  32'(en));
    check_eq({tag, ".clr"},     32'(aux_reg_clr), 32'(clr));
    check_eq({tag, ".done"},    32'(done_o),      32'(done));
    check_eq({tag, ".busy"},    32'(busy_o),      32'(busy));
    check_eq({tag, ".timeout"}, 32'(timeout_o),   32'(to));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Random start requests while busy; all must be ignored.
  task automatic noise();
    start_i = 1'($urandom_range(0, 1));
    limit_i = W'($urandom_range(0, 63));
  endtask

  // One loop. abort_idx: -1 none, -2 abort in CLR, else abort with that ack.
  // hold_idx gets hold_len wait cycles; other indices wait fix_wait cycles,
  // or a random count when fix_wait is negative.
  task automatic run_loop(input int lim, input int abort_idx, input int hold_idx,
                          input int hold_len, input int fix_wait);
    logic [W-1:0] exp_idx;
    int           wt;
    bit           ab;
    exp_q.delete();
    for (int i = 0; i < lim; i++) exp_q.push_back(W'(i));
    start_i = 1'b1;
    limit_i = W'(lim);
    step();
    check_ctl("clr", 0, 0, 1, 0, 1, 0);
    noise();
    if (abort_idx == -2) begin
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      start_i = 1'b0;
      check_ctl("abort_clr", 0, 0, 1, 0, 1, 0);
      step();
      check_ctl("abort_clr_idle", 0, 0, 0, 0, 0, 0);
      return;
    end
    step();
    if (lim == 0) begin
      check_ctl("zero_done", 0, 0, 0, 1, 1, 0);
      start_i = 1'b0;
      step();
      check_ctl("zero_idle", 0, 0, 0, 0, 0, 0);
      return;
    end
    while (exp_q.size() > 0) begin
      exp_idx = exp_q.pop_front();
      if (int'(exp_idx) == hold_idx) wt = hold_len;
      else if (fix_wait >= 0)        wt = fix_wait;
      else                           wt = $urandom_range(0, MAX_WAIT);
      repeat (wt) begin
        check_ctl("wait", 1, 0, 0, 0, 1, 0);
        check_eq("idx_wait", 32'(idx_o), 32'(exp_idx));
        noise();
        step();
      end
      check_ctl("issue", 1, 0, 0, 0, 1, 0);
      check_eq("idx", 32'(idx_o), 32'(exp_idx));
      idx_ack_i = 1'b1;
      ab = (int'(exp_idx) == abort_idx);
      abort_i = ab;
      noise();
      step();
      idx_ack_i = 1'b0;
      abort_i   = 1'b0;
      if (ab) begin
        start_i = 1'b0;
        check_ctl("abort", 0, 0, 1, 0, 1, 0);
        step();
        check_ctl("abort_idle", 0, 0, 0, 0, 0, 0);
        check_eq("abort_reg", 32'(aux_cnt), 32'd0);
        return;
      end
      if (exp_q.size() > 0) begin
        check_ctl("incr", 0, 1, 0, 0, 1, 0);
        check_eq("next_val", 32'(aux_reg_i), 32'(exp_idx) + 32'd1);
        noise();
        step();
      end else begin
        check_ctl("done", 0, 0, 0, 1, 1, 0);
        start_i = 1'b0;
        step();
        check_ctl("idle", 0, 0, 0, 0, 0, 0);
        check_eq("reg_hold", 32'(aux_cnt), 32'(lim - 1));
      end
    end
  endtask

`ifdef AUX_CNT_CTRL_TIMEOUT_EN
  // mode 0: no ack, timeout taken; 1: ack on expiry cycle; 2: abort on expiry cycle.
  task automatic timeout_case(input int mode);
    start_i = 1'b1;
    limit_i = W'(3);
    step();
    start_i = 1'b0;
    step();
    for (int c = 0; c < TO - 1; c++) begin
      check_ctl("to_wait", 1, 0, 0, 0, 1, 0);
      step();
    end
    check_ctl("to_last", 1, 0, 0, 0, 1, 0);
    if (mode == 1) begin
      idx_ack_i = 1'b1;
      step();
      idx_ack_i = 1'b0;
      check_ctl("to_ack_wins", 0, 1, 0, 0, 1, 0);
      for (int k = 1; k < 3; k++) begin
        step();
        check_eq("to_idx", 32'(idx_o), 32'(k));
        check_ctl("to_issue", 1, 0, 0, 0, 1, 0);
        idx_ack_i = 1'b1;
        step();
        idx_ack_i = 1'b0;
      end
      check_ctl("to_done", 0, 0, 0, 1, 1, 0);
    end else if (mode == 2) begin
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      check_ctl("to_abort", 0, 0, 1, 0, 1, 0);
    end else begin
      step();
      check_ctl("timeout", 0, 0, 1, 0, 1, 1);
    end
    step();
    check_ctl("to_idle", 0, 0, 0, 0, 0, 0);
  endtask
`endif

  // ---------------- main sequence ----------------
  initial begin
    int lim;
    int r;
    int ab;
    n_vec     = 0;
    n_bad     = 0;
    rstn      = 1'b0;
    start_i   = 1'b0;
    abort_i   = 1'b0;
    limit_i   = '0;
    idx_ack_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_ctl("reset", 0, 0, 0, 0, 0, 0);
    check_eq("reset_next", 32'(aux_reg_i), 32'd1);
    rstn = 1'b1;
    step();

    // Directed: basic loop, zero limit, long hold, abort on ack, max limit.
    run_loop(3, -1, -1, 0, 1);
    run_loop(0, -1, -1, 0, 0);
    run_loop(5, -1, 1, HOLD_LEN, 0);
    run_loop(5, 2, -1, 0, 0);
    run_loop(4, -2, -1, 0, 0);
    run_loop(63, -1, -1, 0, 0);

    // abort while idle is ignored
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check_ctl("abort_in_idle", 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a loop clears outputs immediately.
    start_i = 1'b1;
    limit_i = W'(5);
    step();
    start_i = 1'b0;
    step();
    step();
    rstn = 1'b0;
    #1;
    check_ctl("rst_mid", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step();
    step();
    check_ctl("rst_stay_idle", 0, 0, 0, 0, 0, 0);
    run_loop(2, -1, -1, 0, 0);

`ifdef AUX_CNT_CTRL_TIMEOUT_EN
    timeout_case(0);
    timeout_case(1);
    timeout_case(2);
`endif

    // Randomized loops with random waits, aborts and stray starts.
    for (int it = 0; it < 40; it++) begin
      lim = ($urandom_range(0, 9) == 0) ? 63 : $urandom_range(0, 8);
      r   = $urandom_range(0, 5);
      if (r == 0 && lim > 0) ab = $urandom_range(0, lim - 1);
      else if (r == 1)       ab = -2;
      else                   ab = -1;
      run_loop(lim, ab, -1, 0, -1);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
